// File: rtl/spm_rr_scheduler_if.sv
// Requester/consumer bundle of the shared-multiplier round-robin scheduler.
// The scheduler uses the slave modport; requester-side logic or a bench uses master.
interface spm_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic signed [15:0]   resp_product;
    logic                 resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, resp_err
    );
endinterface

// File: rtl/spm_rr_scheduler.sv
// Round-robin scheduler sharing one serial multiplier among NUM_REQ requesters.
// Holds a single job: IDLE (grant) -> ISSUE (start pulse) -> WAIT (done/timeout) -> RESP.
module spm_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    spm_rr_scheduler_if.slave  bus,
    output logic               busy,
    output logic               mul_start,
    output logic signed [7:0]  mul_multiplicand,
    output logic signed [7:0]  mul_multiplier,
    input  logic signed [15:0] mul_product,
    input  logic               mul_done
);
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_vld;
    logic [ID_W:0]      w_sum;
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_ready;
    logic signed [7:0]  r_a;
    logic signed [7:0]  r_b;
    logic signed [7:0]  w_a_sel;
    logic signed [7:0]  w_b_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic signed [15:0] r_prod;
    logic               r_err;

    // Cyclic search for the first requesting lane at or after the pointer.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_rot     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end
            w_rot = bus.req_valid >> w_sum;
            if (!w_gnt_vld && w_rot[0]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_a_sel = 8'(bus.req_a >> {w_gnt_idx, 3'b000});
    assign w_b_sel = 8'(bus.req_b >> {w_gnt_idx, 3'b000});

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_ready     = NUM_REQ'(1) << w_gnt_idx;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_done || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job registers; mul_done is only sampled in WAIT so a stale level is never seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_id <= w_gnt_idx;
                        r_a  <= w_a_sel;
                        r_b  <= w_b_sel;
                    end
                end
                S_ISSUE: begin
                    r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_prod <= mul_product;
                        r_err  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_prod <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.resp_valid   = (r_state == S_RESP);
    assign bus.resp_id      = r_id;
    assign bus.resp_product = r_prod;
    assign bus.resp_err     = r_err;
    assign busy             = (r_state != S_IDLE);
    assign mul_start        = (r_state == S_ISSUE);
    assign mul_multiplicand = r_a;
    assign mul_multiplier   = r_b;
endmodule

// File: tb/tb_spm_rr_scheduler.sv
// Bench for spm_rr_scheduler: behavioural 8-cycle multiplier, response scoreboard,
// table-driven single jobs and hand-written fairness/backpressure/timeout/reset sequences.
module tb_spm_rr_scheduler;
    logic               clk;
    logic               rst_n;
    logic               busy;
    logic               mul_start;
    logic signed [7:0]  mul_multiplicand;
    logic signed [7:0]  mul_multiplier;
    logic signed [15:0] mul_product;
    logic               mul_done;

    spm_rr_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    spm_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .busy             (busy),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: busy 8 cycles after start, done is a level cleared by start.
    logic signed [7:0] mdl_a;
    logic signed [7:0] mdl_b;
    int                mdl_cnt;
    bit                never_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt     <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
            mdl_a       <= '0;
            mdl_b       <= '0;
        end else if (mul_start) begin
            mdl_cnt  <= 8;
            mul_done <= 1'b0;
            mdl_a    <= mul_multiplicand;
            mdl_b    <= mul_multiplier;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && !never_done) begin
                mul_done    <= 1'b1;
                mul_product <= mdl_a * mdl_b;
            end
        end
    end

    typedef struct {
        int id;
        int prod;
        int err;
    } exp_t;

    typedef struct {
        int mask;
        int gnt;
        int a;
        int b;
        int prod;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[6];
    int   n_chk;
    int   n_pass;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input int a, input int b);
        bus.req_a[lane*8 +: 8] = 8'(a);
        bus.req_b[lane*8 +: 8] = 8'(b);
    endtask

    task automatic push_exp(input int id, input int prod, input int err);
        exp_t e;
        e.id   = id;
        e.prod = prod;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_ctrl"}, int'({bus.req_ready, bus.resp_valid, busy, mul_start}), 0);
        check({nm, "_resp"}, int'({bus.resp_err, bus.resp_id, bus.resp_product}), 0);
        check({nm, "_ops"}, int'({mul_multiplicand, mul_multiplier}), 0);
    endtask

    // Scoreboard: each response handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: got id=%0d product=%0d, expected no response",
                         bus.resp_id, bus.resp_product);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_id", int'(bus.resp_id), e.id);
                check("resp_product", int'(bus.resp_product), e.prod);
                check("resp_err", int'(bus.resp_err), e.err);
            end
        end
    end

    // One job through a mask; lat is the cycle (relative to acceptance) resp_valid rises.
    task automatic run_job(input string nm, input int mask, input int gnt,
                           input int prod, input int err, input int lat);
        int n;
        tick();
        bus.req_valid = 4'(mask);
        push_exp(gnt, prod, err);
        @(negedge clk);
        check({nm, "_grant"}, int'(bus.req_ready), 1 << gnt);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        n = 1;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, n, lat);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int hs;
        int bad_stable;
        int bad_ready;
        int cap_id;
        int cap_prod;
        int cap_err;

        n_chk          = 0;
        n_pass         = 0;
        never_done     = 1'b0;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        tbl[0] = '{mask: 4'b0001, gnt: 0, a: -128, b: -128, prod: 16384};
        tbl[1] = '{mask: 4'b0010, gnt: 1, a: -128, b: 127,  prod: -16256};
        tbl[2] = '{mask: 4'b0010, gnt: 1, a: -5,   b: -6,   prod: 30};
        tbl[3] = '{mask: 4'b0100, gnt: 2, a: 127,  b: -1,   prod: -127};
        tbl[4] = '{mask: 4'b0011, gnt: 0, a: -1,   b: -1,   prod: 1};
        tbl[5] = '{mask: 4'b1000, gnt: 3, a: 0,    b: -9,   prod: 0};

        #3;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single job with cycle-accurate timing and requests ignored while busy.
        tick();
        set_lane(0, 7, -3);
        bus.req_valid = 4'b0001;
        push_exp(0, -21, 0);
        @(negedge clk);
        check("t1_req_ready", int'(bus.req_ready), 1);
        check("t1_busy_idle", int'(busy), 0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("t1_mul_start", int'(mul_start), 1);
        check("t1_multiplicand", int'(mul_multiplicand), 7);
        check("t1_multiplier", int'(mul_multiplier), -3);
        check("t1_busy", int'(busy), 1);
        tick();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("t1_ready_in_wait", int'(bus.req_ready), 0);
        check("t1_start_once", int'(mul_start), 0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        n = 3;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", n, 11);
        tick();

        // Table: signs, extremes, back-to-back same requester, pointer wrap.
        for (int i = 0; i < 6; i++) begin
            set_lane(tbl[i].gnt, tbl[i].a, tbl[i].b);
            run_job($sformatf("vec%0d", i), tbl[i].mask, tbl[i].gnt, tbl[i].prod, 0, 11);
        end

        // Fairness: all lanes held, five jobs must rotate 0,1,2,3,0.
        tick();
        for (int i = 0; i < 4; i++) set_lane(i, i + 1, -(i + 2));
        bus.req_valid = 4'b1111;
        push_exp(0, -2, 0);
        push_exp(1, -6, 0);
        push_exp(2, -12, 0);
        push_exp(3, -20, 0);
        push_exp(0, -2, 0);
        pulses = 0;
        hs     = 0;
        for (int c = 0; c < 200 && hs < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                pulses++;
                if (!$onehot(bus.req_ready)) begin
                    check("fair_onehot", int'(bus.req_ready), 0);
                end
            end
            if (bus.resp_valid && bus.resp_ready) hs++;
            if (pulses == 5 && bus.req_valid != 0) begin
                tick();
                bus.req_valid = '0;
            end
        end
        check("fair_pulses", pulses, 5);
        check("fair_handshakes", hs, 5);
        tick();

        // Backpressure: response held 20 cycles with all requesters asserting.
        bus.resp_ready = 1'b0;
        set_lane(2, -7, 9);
        bus.req_valid = 4'b0100;
        push_exp(2, -63, 0);
        @(negedge clk);
        check("bp_grant", int'(bus.req_ready), 4);
        tick();
        bus.req_valid = '0;
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        cap_id   = int'(bus.resp_id);
        cap_prod = int'(bus.resp_product);
        cap_err  = int'(bus.resp_err);
        check("bp_product_seen", cap_prod, -63);
        tick();
        bus.req_valid = 4'b1111;
        bad_stable = 0;
        bad_ready  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.resp_valid || int'(bus.resp_id) != cap_id ||
                int'(bus.resp_product) != cap_prod || int'(bus.resp_err) != cap_err) bad_stable++;
            if (bus.req_ready != 0) bad_ready++;
        end
        check("bp_stable", bad_stable, 0);
        check("bp_no_ready", bad_ready, 0);
        tick();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", int'(bus.resp_valid), 1);
        tick();
        @(negedge clk);
        check("bp_idle_valid", int'(bus.resp_valid), 0);
        check("bp_idle_busy", int'(busy), 0);

        // Timeout: 16 WAIT cycles without done, then a normal job.
        never_done = 1'b1;
        set_lane(3, 5, 5);
        run_job("tmo", 4'b1000, 3, 0, 1, 18);
        never_done = 1'b0;
        set_lane(0, 3, 4);
        run_job("post_tmo", 4'b0001, 0, 12, 0, 11);

        // Reset in WAIT drops the job; pointer returns to 0.
        tick();
        set_lane(1, 2, 3);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("rst_job_grant", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        check("rst_in_wait", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        repeat (2) tick();
        rst_n = 1'b1;
        set_lane(0, -3, 7);
        run_job("after_rst", 4'b1111, 0, -21, 0, 11);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
